// File: rtl/fifo4_pkg.sv
// Shared sizing constants and types for the 4-entry synchronous FIFO.
package fifo4_pkg;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fifo4_occ.sv
// Occupancy counter: tracks accepted pushes/pops and derives full/empty from the registered count.
module fifo4_occ
    import fifo4_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: if (count != CNT_W'(DEPTH)) count <= count + 3'd1;
                2'b01: if (count != '0)            count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Flags depend only on the count register, never on push/pop requests.
    always_comb begin
        full  = (count == CNT_W'(DEPTH));
        empty = (count == '0);
    end

endmodule

// File: rtl/fifo4_sync.sv
// 4-entry synchronous FIFO with registered read data, pop-valid strobe and sticky error flags.
module fifo4_sync
    import fifo4_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    logic [DATA_W-1:0] mem [DEPTH];
    ptr_t              wr_ptr;
    ptr_t              rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO is allowed only when a pop frees a slot on the same edge.
    always_comb begin
        pop_ok  = rd_en && !empty;
        push_ok = wr_en && (!full || pop_ok);
    end

    fifo4_occ u_occ (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_ok),
        .pop     (pop_ok),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 2'd1;
            end
            // New errors take priority over a simultaneous clear.
            overflow  <= (wr_en && !push_ok) || (overflow && !clr_err);
            underflow <= (rd_en && !pop_ok)  || (underflow && !clr_err);
        end
    end

endmodule

// File: doc/fifo4_sync.md
FIFO4_SYNC -- requirements
Module: fifo4_sync

Interface
REQ-001 Parameter DATA_W, default 8: width of each stored word.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port wr_en, input, 1: push request.
REQ-005 Port wr_data, input, DATA_W: word to push, sampled when a push is accepted.
REQ-006 Port rd_en, input, 1: pop request.
REQ-007 Port rd_data, output, DATA_W: registered popped word.
REQ-008 Port rd_valid, output, 1: rd_data holds a word popped in the previous cycle.
REQ-009 Port count, output, 3: current occupancy, range 0..4.
REQ-010 Port full, output, 1: count==4.
REQ-011 Port empty, output, 1: count==0.
REQ-012 Port overflow, output, 1: sticky flag; a push was rejected.
REQ-013 Port underflow, output, 1: sticky flag; a pop was rejected.
REQ-014 Port clr_err, input, 1: synchronous clear of overflow and underflow.

Function
REQ-015 Storage shall be exactly 4 entries of DATA_W bits, addressed by 2-bit write and read pointers that wrap 3->0.
REQ-016 A push shall be accepted when wr_en=1 and (full=0 or a pop is accepted in the same cycle).
REQ-017 A pop shall be accepted when rd_en=1 and empty=0.
REQ-018 On an accepted push, wr_data shall be written at the write pointer and the write pointer shall advance by 1.
REQ-019 On an accepted pop, the entry at the read pointer shall load rd_data on the same edge and the read pointer shall advance by 1.
REQ-020 Pop latency: rd_valid shall be 1 in the cycle after an accepted pop, otherwise 0.
REQ-021 rd_data shall hold its last value when no pop is accepted.
REQ-022 count shall change as follows: push only +1; pop only -1; both or neither unchanged.
REQ-023 count shall never leave 0..4.
REQ-024 When full, a push with rd_en=1 shall be accepted together with the pop, and count shall stay 4.
REQ-025 When empty, a push with rd_en=1 shall accept only the push; the pop shall be rejected and count shall become 1.
REQ-026 No bypass: a word is never readable in the cycle it is written.
REQ-027 full, empty and count shall be registered or derived from registered count only, with no combinational path from wr_en or rd_en.
REQ-028 A rejected push (wr_en=1, not accepted) shall set overflow on the next edge.
REQ-029 A rejected pop (rd_en=1, empty=1) shall set underflow on the next edge.
REQ-030 overflow and underflow shall hold until clr_err=1 or reset.
REQ-031 If clr_err and a new error occur in the same cycle, the flag shall be set (set wins).

Reset
REQ-032 reset_n=0 shall immediately force the pointers to 0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow=0 and underflow=0.
REQ-033 Reset asserted mid-operation shall discard all contents; storage array contents need not be cleared.
REQ-034 Reset deassertion shall take effect synchronously; the first push is accepted on the first edge after release.

Structure
REQ-035 A shared package fifo4_pkg shall hold the DEPTH=4 constant, the pointer width (2) and the count width (3).
REQ-036 Occupancy tracking shall be a sub-module fifo4_occ (inputs: accepted push, accepted pop; outputs: count, full, empty), using an active-low asynchronous reset.
REQ-037 Storage, pointers and error flags shall reside in fifo4_sync.

Verification
REQ-038 Reset, then push A1,A2,A3,A4 -> full=1 and count=4 after the 4th edge; a 5th push -> overflow=1, count stays 4.
REQ-039 From full, pop 4 times -> rd_data A1,A2,A3,A4 in order with rd_valid=1 each following cycle; then empty=1 and count=0.
REQ-040 Empty with wr_en=rd_en=1 and wr_data=0x5A -> count=1, underflow=1, rd_valid=0 next cycle.
REQ-041 Full with wr_en=rd_en=1 -> oldest word is output, the new word is stored, count stays 4, overflow stays 0.
REQ-042 Run 10 interleaved push/pop cycles across the pointer wrap -> data order preserved; apply clr_err -> overflow=underflow=0.
REQ-043 Assert reset_n=0 at count=3 between edges -> all outputs reach reset values before the next edge; after release empty=1.
